// File: rtl/mul_ctrl_if.sv
// Handshake and multiplier-array bundle for the mul_ctrl stage.
// slave: the control stage; master: requester, consumer and array.
interface mul_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         op;
  logic [WIDTH-1:0]   src1;
  logic [WIDTH-1:0]   src2;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] mul_p;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;

  modport slave (
    input  in_valid, op, src1, src2,
    input  mul_p, out_ready,
    output in_ready, mul_a, mul_b,
    output out_valid, result
  );

  modport master (
    output in_valid, op, src1, src2,
    output mul_p, out_ready,
    input  in_ready, mul_a, mul_b,
    input  out_valid, result
  );
endinterface

// File: rtl/mul_ctrl.sv
// Two-stage M-extension multiply control around an external
// unsigned array: sign strip in S1, sign restore/select in S2.
module mul_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_flush,
  mul_ctrl_if.slave bus
);
  localparam logic [WIDTH-1:0] A_ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] P_ONE =
    {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_a_mag;
  logic [WIDTH-1:0] r_b_mag;
  logic             r_neg;
  logic             r_hi_sel;
  logic [WIDTH-1:0] r_result;

  logic               w_adv1;
  logic               w_adv2;
  logic               w_acc;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_p_fix;
  logic [WIDTH-1:0]   w_res;

  assign w_adv2 = !r_s2_valid || bus.out_ready;
  assign w_adv1 = !r_s1_valid || w_adv2;
  assign w_acc  = bus.in_valid && w_adv1;

  // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 so
  assign w_a_neg = (bus.op == 2'd1 || bus.op == 2'd2)
                   && bus.src1[WIDTH-1];
  assign w_b_neg = (bus.op == 2'd1) && bus.src2[WIDTH-1];

  assign w_a_mag = w_a_neg ? (~bus.src1 + A_ONE) : bus.src1;
  assign w_b_mag = w_b_neg ? (~bus.src2 + A_ONE) : bus.src2;

  assign w_p_fix = r_neg ? (~bus.mul_p + P_ONE) : bus.mul_p;
  assign w_res   = r_hi_sel ? w_p_fix[2*WIDTH-1:WIDTH]
                            : w_p_fix[WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_a_mag    <= '0;
      r_b_mag    <= '0;
      r_neg      <= 1'b0;
      r_hi_sel   <= 1'b0;
    end else if (i_flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_acc) begin
      r_s1_valid <= 1'b1;
      r_a_mag    <= w_a_mag;
      r_b_mag    <= w_b_mag;
      r_neg      <= w_a_neg ^ w_b_neg;
      r_hi_sel   <= (bus.op != 2'd0);
    end else if (w_adv2) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
    end else if (i_flush) begin
      r_s2_valid <= 1'b0;
    end else if (r_s1_valid && w_adv2) begin
      r_s2_valid <= 1'b1;
      r_result   <= w_res;
    end else if (bus.out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_adv1;
  assign bus.mul_a     = r_a_mag;
  assign bus.mul_b     = r_b_mag;
  assign bus.out_valid = r_s2_valid;
  assign bus.result    = r_result;
endmodule
